// File: rtl/mips_grf_if.sv
// Bus bundle between the datapath and the general-purpose register file.
// The datapath drives the write strobe and all indices. The register file returns the two read words.
interface mips_grf_if;
  logic        writeEnable;
  logic [31:0] PCReg;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] readData1;
  logic [31:0] readData2;

  modport master (
    output writeEnable, PCReg, readReg1, readReg2, writeReg, writeData,
    input  readData1, readData2
  );

  modport slave (
    input  writeEnable, PCReg, readReg1, readReg2, writeReg, writeData,
    output readData1, readData2
  );
endinterface

// File: rtl/mips_grf.sv
// MIPS general-purpose register file: 32 x 32 bits, two combinational read ports and one clocked write port.
// Register $0 always reads as zero. A write in flight is bypassed to the read ports.
module mips_grf (
  input  logic       clk,
  input  logic       reset,
  mips_grf_if.slave  grf
);

  logic [31:0] regs [0:31];
  logic        write_hit;

  // A write index of X makes the comparison X, so the write does not happen and $0 is left untouched.
  assign write_hit = grf.writeEnable && (grf.writeReg != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (write_hit) begin
      regs[grf.writeReg] <= grf.writeData;
    end
  end

  // The bypass only applies while reset is high, so both ports read 0 throughout reset.
  always_comb begin
    grf.readData1 = regs[grf.readReg1];
    if (grf.readReg1 == 5'd0) begin
      grf.readData1 = 32'd0;
    end else if (grf.writeEnable && reset && (grf.readReg1 == grf.writeReg)) begin
      grf.readData1 = grf.writeData;
    end
  end

  always_comb begin
    grf.readData2 = regs[grf.readReg2];
    if (grf.readReg2 == 5'd0) begin
      grf.readData2 = 32'd0;
    end else if (grf.writeEnable && reset && (grf.readReg2 == grf.writeReg)) begin
      grf.readData2 = grf.writeData;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && write_hit) begin
      $display("@%08h: $%02d <= %08h", grf.PCReg, grf.writeReg, grf.writeData);
    end
  end
`endif

endmodule

// File: tb/tb_mips_grf.sv
// Directed bench for mips_grf: reset sweep, table of write/read/bypass vectors, and an async reset mid-run.
module tb_mips_grf;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_q[$];

  mips_grf_if grf ();

  mips_grf dut (
    .clk   (clk),
    .reset (reset),
    .grf   (grf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [4:0] rr1, input logic [4:0] rr2);
    grf.writeEnable = we;
    grf.writeReg    = wr;
    grf.writeData   = wd;
    grf.PCReg       = pc;
    grf.readReg1    = rr1;
    grf.readReg2    = rr2;
  endtask

  // Every register on both ports must read zero. The write inputs target the register being read, to exercise the bypass.
  task automatic sweep_zero(input string name, input logic we);
    for (int i = 0; i < 32; i++) begin
      drive(we, 5'(i), 32'hFFFF_FFFF, 32'h0, 5'(i), 5'(31 - i));
      #1;
      chk({name, "_rd1"}, grf.readData1, 32'd0);
      chk({name, "_rd2"}, grf.readData2, 32'd0);
    end
  endtask

  initial begin
    // Vectors: inputs applied after a falling edge, reads checked before the next rising edge, write taken on it.
    vecs[0]  = '{1'b1, 5'd0,  32'd3,          32'h0,        5'd0,  5'd0,  32'd0,          32'd0};
    vecs[1]  = '{1'b0, 5'd0,  32'd0,          32'h0,        5'd0,  5'd0,  32'd0,          32'd0};
    vecs[2]  = '{1'b1, 5'd10, 32'h10,         32'h12345678, 5'd10, 5'd3,  32'h10,         32'd0};
    vecs[3]  = '{1'b0, 5'd0,  32'd0,          32'h0,        5'd3,  5'd10, 32'd0,          32'h10};
    vecs[4]  = '{1'b1, 5'd5,  32'hDEADBEEF,   32'h100,      5'd5,  5'd5,  32'hDEADBEEF,   32'hDEADBEEF};
    vecs[5]  = '{1'b0, 5'd5,  32'h12345,      32'h0,        5'd5,  5'd10, 32'hDEADBEEF,   32'h10};
    vecs[6]  = '{1'b1, 5'd5,  32'h0000CAFE,   32'h104,      5'd5,  5'd6,  32'h0000CAFE,   32'd0};
    vecs[7]  = '{1'b0, 5'd5,  32'd1,          32'h0,        5'd5,  5'd5,  32'h0000CAFE,   32'h0000CAFE};
    vecs[8]  = '{1'b0, 5'd7,  32'hFFFFFFFF,   32'h0,        5'd7,  5'd7,  32'd0,          32'd0};
    vecs[9]  = '{1'b0, 5'd7,  32'hFFFFFFFF,   32'h0,        5'd7,  5'd7,  32'd0,          32'd0};
    vecs[10] = '{1'b0, 5'd7,  32'hFFFFFFFF,   32'h0,        5'd7,  5'd31, 32'd0,          32'd0};
    vecs[11] = '{1'b1, 5'd31, 32'hA5A5A5A5,   32'h108,      5'd30, 5'd31, 32'd0,          32'hA5A5A5A5};
    vecs[12] = '{1'b0, 5'd0,  32'd0,          32'h0,        5'd31, 5'd5,  32'hA5A5A5A5,   32'h0000CAFE};

    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    #2 reset = 1'b0;
    #1;
    sweep_zero("reset_sweep", 1'b1);

    // Rising edges with reset low must not write.
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h3333_3333, 32'h0, 5'd3, 5'd3);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sweep_zero("post_reset", 1'b0);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].we, vecs[k].wr, vecs[k].wd, vecs[k].pc, vecs[k].rr1, vecs[k].rr2);
      #1;
      chk($sformatf("vec%0d_rd1", k), grf.readData1, vecs[k].exp1);
      chk($sformatf("vec%0d_rd2", k), grf.readData2, vecs[k].exp2);
    end

    // Fill $1..$31 with index*4, then read each back.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'(i * 4), 32'h200 + 32'(i * 4), 5'd0, 5'd0);
      exp_q.push_back(32'(i * 4));
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      grf.readReg1 = 5'(i);
      grf.readReg2 = 5'(32 - i);
      #1;
      chk("fill_rd1", grf.readData1, exp_q.pop_front());
      chk("fill_rd2", grf.readData2, 32'((32 - i) * 4));
    end

    // Async reset between clock edges clears everything without a clock.
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    sweep_zero("async_reset", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    sweep_zero("after_async", 1'b0);

    @(negedge clk);
    drive(1'b1, 5'd9, 32'h0000_0099, 32'h300, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd8);
    #1;
    chk("rewrite_rd1", grf.readData1, 32'h0000_0099);
    chk("rewrite_rd2", grf.readData2, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
